// File: rtl/ones_frame_gen.sv
// Pattern source: turns a count N into a DEPTH-bit serial frame with N evenly
// spread ones (first-order accumulator), also assembled into a parallel word.
module ones_frame_gen #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt,
  output logic             cnt_ready,
  output logic             busy,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             frame_last,
  output logic             word_valid,
  output logic [DEPTH-1:0] word
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0]  DEPTH_ACC = (WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   acc_n;
  logic [IW-1:0]    idx_reg;
  logic [DEPTH-1:0] shift_reg;
  logic             at_last;
  logic             accept;
  logic             b;

  assign at_last = (state_reg == RUN) && (idx_reg == LAST_IDX);
  assign accept  = cnt_valid && cnt_ready;
  assign acc_n   = acc_reg + {1'b0, n_reg};
  assign b       = (acc_n >= DEPTH_ACC);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: a request taken on the last bit chains the next frame
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (at_last) state_next = cnt_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    cnt_ready = (state_reg == IDLE) || at_last;
    busy      = (state_reg == RUN);
  end

  // Accumulator, bit index and registered serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg      <= '0;
      acc_reg    <= '0;
      idx_reg    <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      frame_last <= 1'b0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      bit_valid  <= (state_reg == RUN);
      bit_out    <= (state_reg == RUN) && b;
      frame_last <= at_last;
      word_valid <= frame_last;
      if (frame_last) word <= shift_reg;
      if (accept) begin
        n_reg   <= cnt;
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (state_reg == RUN) begin
        acc_reg <= b ? (acc_n - DEPTH_ACC) : acc_n;
        idx_reg <= at_last ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // Each frame bit lands in its own slot; every slot is rewritten every frame
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          shift_reg[gi] <= 1'b0;
        else if ((state_reg == RUN) && (idx_reg == IW'(gi)))
          shift_reg[gi] <= b;
      end
    end
  endgenerate

endmodule

// File: tb/tb_ones_frame_gen.sv
// Scoreboard bench for ones_frame_gen: driver queues accepted counts, a monitor
// checks every emitted bit and word against the floor-formula reference.
module tb_ones_frame_gen;
  localparam int W = 6;
  localparam int D = 63;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cnt_valid = 1'b0;
  logic [W-1:0] cnt = '0;
  logic         cnt_ready, busy, bit_valid, bit_out, frame_last, word_valid;
  logic [D-1:0] word;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_q[$];
  int mon_k = 0;
  int cur_n = 0;
  int frames_done = 0;
  logic [D-1:0] build_word = '0;
  logic [D-1:0] pend_word = '0;
  logic [D-1:0] last_word = '0;
  bit pend = 1'b0;

  ones_frame_gen #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt(cnt),
    .cnt_ready(cnt_ready), .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out),
    .frame_last(frame_last), .word_valid(word_valid), .word(word)
  );

  always #5 clk = ~clk;

  function automatic bit exp_bit(input int n, input int k);
    return ((k + 1) * n) / D > (k * n) / D;
  endfunction

  task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_bit_valid", D'(bit_valid), '0);
      chk("rst_bit_out", D'(bit_out), '0);
      chk("rst_frame_last", D'(frame_last), '0);
      chk("rst_word_valid", D'(word_valid), '0);
      chk("rst_busy", D'(busy), '0);
      chk("rst_word", word, '0);
      chk("rst_cnt_ready", D'(cnt_ready), D'(1));
      exp_q.delete();
      mon_k = 0;
      pend = 1'b0;
      last_word = '0;
    end else begin
      chk("word_valid", D'(word_valid), D'(pend));
      if (pend) begin
        chk("word", word, pend_word);
        chk("word_popcount", D'($countones(word)), D'($countones(pend_word)));
        last_word = pend_word;
        pend = 1'b0;
      end else begin
        chk("word_stable", word, last_word);
      end
      if (mon_k != 0 && !bit_valid) chk("bit_gap", D'(bit_valid), D'(1));
      if (bit_valid) begin
        if (mon_k == 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", D'(bit_valid), '0);
            cur_n = 0;
          end else begin
            cur_n = exp_q.pop_front();
          end
          build_word = '0;
        end
        chk($sformatf("bit n=%0d k=%0d", cur_n, mon_k), D'(bit_out), D'(exp_bit(cur_n, mon_k)));
        chk("frame_last", D'(frame_last), D'(mon_k == D - 1));
        if (!frame_last) chk("busy_mid_frame", D'(busy), D'(1));
        build_word[mon_k] = exp_bit(cur_n, mon_k);
        mon_k++;
        if (mon_k == D) begin
          chk("frame_popcount", D'($countones(build_word)), D'(cur_n));
          $display("frame n=%0d done, expected word %h", cur_n, build_word);
          pend_word = build_word;
          pend = 1'b1;
          mon_k = 0;
          frames_done++;
        end
      end
      if (!busy) chk("cnt_ready_idle", D'(cnt_ready), D'(1));
      else       chk("cnt_ready_run", D'(cnt_ready), D'(mon_k == D - 1));
    end
  end

  // Entered just after a negedge; returns just after the negedge following acceptance
  task automatic send(input int n);
    int w = 0;
    bit done = 1'b0;
    cnt_valid = 1'b1;
    cnt = W'(n);
    while (!done) begin
      #1;
      if (cnt_ready) begin
        exp_q.push_back(n);
        done = 1'b1;
      end
      @(negedge clk);
      w++;
      if (!done && w > 300) begin
        chk("send_timeout", D'(0), D'(1));
        done = 1'b1;
      end
    end
  endtask

  task automatic idle_input();
    cnt_valid = 1'b0;
    cnt = W'($urandom);
  endtask

  task automatic wait_frames(input int target);
    int w = 0;
    while (frames_done < target && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (frames_done < target) chk("frame_timeout", D'(frames_done), D'(target));
    @(negedge clk);
    @(negedge clk);
  endtask

  int order[64];

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset mid-frame: N=40 interrupted at bit 30
    send(40);
    idle_input();
    begin
      int w = 0;
      while (mon_k != 30 && w < 200) begin @(negedge clk); w++; end
      if (mon_k != 30) chk("reach_idx30", D'(mon_k), D'(30));
    end
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    frames_done = 0;
    send(5);
    idle_input();
    wait_frames(1);

    // Boundary and directed counts
    foreach (order[i]) order[i] = i;
    send(0);  idle_input(); wait_frames(2);
    send(63); idle_input(); wait_frames(3);
    send(1);  idle_input(); wait_frames(4);
    send(21); idle_input(); wait_frames(5);
    send(32); idle_input(); wait_frames(6);

    // Back-to-back with cnt_valid held high
    send(7);
    send(9);
    idle_input();
    wait_frames(8);

    // Random sweep of every N, random gaps or back-to-back chaining
    for (int i = 63; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 64; i++) begin
      send(order[i]);
      if ($urandom_range(2, 0) != 0) begin
        idle_input();
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
    end
    idle_input();
    wait_frames(8 + 64);

    chk("final_queue_empty", D'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
